// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per CLK edge, optional parity bit.
// Define UART_TX_PARITY_EN to compile in the PARITY state and generator.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  w_accept;

    assign w_accept = Data_Valid && (r_state == IDLE || r_state == STOP);

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic w_par_en_nxt;
    logic r_par_typ;
    logic w_par_typ_nxt;
    logic w_parity;

    assign w_parity = (^r_data) ^ r_par_typ;
`else
    logic w_unused;

    assign w_unused = PAR_EN ^ PAR_TYP;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
`ifdef UART_TX_PARITY_EN
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
`endif
        case (r_state)
            IDLE: begin
                if (Data_Valid) w_state_nxt = START;
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end
            DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = r_par_en ? PARITY : STOP;
`else
                    w_state_nxt = STOP;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_state_nxt = STOP;
            end
`endif
            STOP: begin
                w_state_nxt = Data_Valid ? START : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_accept) begin
            w_data_nxt = P_DATA;
`ifdef UART_TX_PARITY_EN
            w_par_en_nxt  = PAR_EN;
            w_par_typ_nxt = PAR_TYP;
`endif
        end
    end

    // Outputs are precomputed from the next state so both leave flops.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            IDLE:   w_busy_nxt = 1'b0;
            START:  w_tx_nxt = 1'b0;
            DATA:   w_tx_nxt = w_data_nxt[w_cnt_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY: w_tx_nxt = w_parity;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else begin
            r_par_en  <= w_par_en_nxt;
            r_par_typ <= w_par_typ_nxt;
        end
    end
`endif

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames, parity, back-to-back, ignore, reset.
// Expected line sequences are hand-written strings, first cycle first.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int nvec  = 0;
    int nfail = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic pe,
                          input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
    endtask

    task automatic play(input string exp, input string tag,
                        input int dv_idx, input logic [7:0] dv_data);
        for (int i = 0; i < exp.len(); i++) begin
            chk($sformatf("%s.tx[%0d]", tag, i), TX_OUT, exp[i] == 8'h31);
            chk($sformatf("%s.busy[%0d]", tag, i), busy, 1'b1);
            if (i == dv_idx) begin
                Data_Valid = 1'b1;
                P_DATA     = dv_data;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b0;
            end
            tick();
            Data_Valid = 1'b0;
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.tx[%0d]", tag, i), TX_OUT, 1'b1);
            chk($sformatf("%s.busy[%0d]", tag, i), busy, 1'b0);
            tick();
        end
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("rst.tx", TX_OUT, 1'b1);
        chk("rst.busy", busy, 1'b0);
        Data_Valid = 1'b1;
        tick();
        tick();
        Data_Valid = 1'b0;
        chk("rst_hold.tx", TX_OUT, 1'b1);
        chk("rst_hold.busy", busy, 1'b0);
        RST = 1'b1;

        accept(8'hA5, 1'b0, 1'b0);
        play("0101001011", "a5", -1, 8'h00);
        idle(2, "a5.idle");

`ifdef UART_TX_PARITY_EN
        accept(8'hA5, 1'b1, 1'b0);
        play("01010010101", "a5even", -1, 8'h00);
        idle(1, "a5even.idle");
        accept(8'hA5, 1'b1, 1'b1);
        play("01010010111", "a5odd", -1, 8'h00);
        idle(1, "a5odd.idle");
        accept(8'h3C, 1'b1, 1'b0);
        play("00011110001", "3ceven", -1, 8'h00);
        idle(1, "3ceven.idle");
`else
        accept(8'hA5, 1'b1, 1'b1);
        play("0101001011", "a5nopar", -1, 8'h00);
        idle(1, "a5nopar.idle");
        accept(8'h3C, 1'b1, 1'b0);
        play("0001111001", "3cnopar", -1, 8'h00);
        idle(1, "3cnopar.idle");
`endif

        accept(8'h0F, 1'b0, 1'b0);
        play("0111100001", "b2b0", 9, 8'hF0);
        play("0000011111", "b2b1", -1, 8'h00);
        idle(1, "b2b.idle");

        accept(8'h00, 1'b0, 1'b0);
        play("0000000001", "ign", 3, 8'hFF);
        idle(3, "ign.idle");

        accept(8'hA5, 1'b0, 1'b0);
        play("01010", "abort", -1, 8'h00);
        chk("abort.bit4.tx", TX_OUT, 1'b0);
        chk("abort.bit4.busy", busy, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("abort.async.tx", TX_OUT, 1'b1);
        chk("abort.async.busy", busy, 1'b0);
        tick();
        chk("abort.held.tx", TX_OUT, 1'b1);
        chk("abort.held.busy", busy, 1'b0);
        RST = 1'b1;
        accept(8'hA5, 1'b0, 1'b0);
        play("0101001011", "after_rst", -1, 8'h00);
        idle(2, "after_rst.idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the number of payload bits per frame.
REQ-002 CLK  input  1  is the bit clock: one serial bit is sent per CLK rising edge, and all state updates on this edge.
REQ-003 RST  input  1  is the reset: asynchronous, active-low.
REQ-004 P_DATA  input  DATA_WIDTH  is the parallel payload to transmit.
REQ-005 Data_Valid  input  1  is a one-cycle request; P_DATA, PAR_EN and PAR_TYP are valid whenever it is high.
REQ-006 PAR_EN  input  1  selects a parity bit in the frame: 1 = include parity.
REQ-007 PAR_TYP  input  1  selects the parity type: 0 = even, 1 = odd.
REQ-008 TX_OUT  output  1  is the serial line, idle high, registered.
REQ-009 busy  output  1  is high while a frame is in flight, registered.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, encoded in a single state register.
REQ-011 A request SHALL be accepted only when Data_Valid=1 at a CLK edge while the state is IDLE or STOP; Data_Valid in any other state is ignored and no frame is dropped from or corrupted in the frame in flight.
REQ-012 On acceptance, P_DATA, PAR_EN and PAR_TYP SHALL be latched internally; later input changes do not affect the frame.
REQ-013 Latency: on the edge that accepts a request, the state goes to START; TX_OUT=0 and busy=1 for the following cycle.
REQ-014 In START, the block SHALL drive TX_OUT=0 for exactly 1 cycle and then move to DATA.
REQ-015 In DATA, the block SHALL drive the latched bits LSB first, one per cycle, for exactly DATA_WIDTH cycles, using a bit counter of width $clog2(DATA_WIDTH).
REQ-016 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, and to STOP otherwise.
REQ-017 In PARITY, TX_OUT SHALL equal the XOR of the latched data, inverted when the latched PAR_TYP=1, for exactly 1 cycle.
REQ-018 In STOP, TX_OUT SHALL be 1 for exactly 1 cycle.
REQ-019 Leaving STOP, the FSM SHALL go to START if a request is accepted on that edge, with no idle gap and busy staying 1; otherwise it goes to IDLE.
REQ-020 In IDLE, TX_OUT SHALL be 1 and busy SHALL be 0.
REQ-021 busy SHALL be 1 in the START, DATA, PARITY and STOP states.
REQ-022 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-023 TX_OUT and busy SHALL be driven from flops only, with no combinational path from any input.

Reset
REQ-024 When RST=0, the block SHALL immediately, regardless of CLK, set state=IDLE, TX_OUT=1, busy=0 and clear the bit counter and the latched data/config.
REQ-025 Reset during a frame SHALL abort that frame with no resumption.
REQ-026 After RST is released, the first acceptance SHALL be possible on the first CLK edge.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state and the parity generator SHALL be compiled in, and the behaviour follows REQ-016 and REQ-017.
REQ-028 With UART_TX_PARITY_EN undefined, the PARITY state and the parity logic SHALL be absent.
REQ-029 With UART_TX_PARITY_EN undefined, PAR_EN and PAR_TYP SHALL remain as ports but be ignored, DATA SHALL always go to STOP, and every frame SHALL be DATA_WIDTH+2 cycles.

Verification
REQ-030 Scenario, P_DATA=0xA5, PAR_EN=0, one Data_Valid pulse -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 cycles, then TX_OUT=1 and busy=0.
REQ-031 Scenario, 0xA5 with PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; each frame is 11 cycles.
REQ-032 Scenario, back-to-back: 0x0F then 0xF0, with the second Data_Valid in the STOP cycle -> the second start bit directly follows the first stop bit and busy never drops.
REQ-033 Scenario, Data_Valid pulsed with P_DATA=0xFF during DATA of a 0x00 frame -> the frame in flight is unchanged (all data bits 0) and no extra frame is sent.
REQ-034 Scenario, RST asserted at data bit 4 -> TX_OUT=1 and busy=0 at once, without a clock edge; a new request after release yields a complete, correct frame.
REQ-035 Scenario, UART_TX_PARITY_EN undefined with PAR_EN=1 and 0x3C -> the frame is 10 cycles with no parity bit.
